// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, opcodes and the result entry layout.
package alu_pkg;

  localparam int NIO = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef struct packed {
    logic [2:0]     op;
    logic           ov;
    logic [NIO-1:0] z;
  } res_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Generic circular FIFO with registered occupancy; no full pass-through.
module alu_result_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Empty slots read as zero so the head is clean after reset.
  assign out_data  = out_valid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wptr] <= in_data;
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result collection stage: result FIFO plus sticky/counted overflow status.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int nIO   = NIO,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [nIO-1:0]   in_z,
  input  logic             in_ov,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [nIO-1:0]   out_z,
  output logic             out_ov,
  output logic [2:0]       out_op,
  output logic             sticky_ov,
  output logic [CNT_W-1:0] ov_count,
  input  logic             clr_status
);

  localparam int W = nIO + 4;

  logic [W-1:0] in_data;
  logic [W-1:0] out_data;
  logic         ov_push;

  assign in_data = {in_op, in_ov, in_z};
  assign {out_op, out_ov, out_z} = out_data;
  assign ov_push = in_valid && in_ready && in_ov;

  alu_result_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // An overflowed push in the clearing cycle restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ov <= 1'b0;
      ov_count  <= '0;
    end else if (ov_push) begin
      sticky_ov <= 1'b1;
      if (clr_status)
        ov_count <= CNT_W'(1);
      else if (ov_count != '1)
        ov_count <= ov_count + 1'b1;
    end else if (clr_status) begin
      sticky_ov <= 1'b0;
      ov_count  <= '0;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with a result scoreboard.
module tb_alu_result_stage;
  import alu_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_z;
  logic       in_ov;
  logic [2:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_z;
  logic       out_ov;
  logic [2:0] out_op;
  logic       sticky_ov;
  logic [7:0] ov_count;
  logic       clr_status;

  logic       s_in_valid;
  logic       s_in_ready;
  logic [7:0] s_in_z;
  logic       s_in_ov;
  logic [2:0] s_in_op;
  logic       s_out_valid;
  logic       s_out_ready;
  logic [7:0] s_out_z;
  logic       s_out_ov;
  logic [2:0] s_out_op;
  logic       s_sticky_ov;
  logic [1:0] s_ov_count;
  logic       s_clr_status;

  int pass_cnt = 0;
  int total_cnt = 0;
  res_t sb[$];

  alu_result_stage #(.nIO(8), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_z(in_z), .in_ov(in_ov), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_ov(out_ov), .out_op(out_op),
    .sticky_ov(sticky_ov), .ov_count(ov_count),
    .clr_status(clr_status)
  );

  alu_result_stage #(.nIO(8), .DEPTH(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_z(s_in_z), .in_ov(s_in_ov), .in_op(s_in_op),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_z(s_out_z), .out_ov(s_out_ov), .out_op(s_out_op),
    .sticky_ov(s_sticky_ov), .ov_count(s_ov_count),
    .clr_status(s_clr_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    res_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_pop", 32'(sb.size()), 1);
      end else begin
        e = sb.pop_front();
        chk("sb_z", {24'd0, out_z}, {24'd0, e.z});
        chk("sb_ov", {31'd0, out_ov}, {31'd0, e.ov});
        chk("sb_op", {29'd0, out_op}, {29'd0, e.op});
      end
    end
  end

  task automatic send(input logic [7:0] z, input logic ov,
                      input logic [2:0] op);
    int t;
    in_z = z;
    in_ov = ov;
    in_op = op;
    in_valid = 1'b1;
    sb.push_back('{op: op, ov: ov, z: z});
    t = 0;
    while (!in_ready && t < 20) begin
      step();
      t++;
    end
    chk("send_ready", {31'd0, in_ready}, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 16) begin
      step();
      t++;
    end
    chk("drain_empty", 32'(sb.size()), 0);
    step();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_out_z"}, {24'd0, out_z}, 0);
    chk({tag, "_out_ov"}, {31'd0, out_ov}, 0);
    chk({tag, "_out_op"}, {29'd0, out_op}, 0);
    chk({tag, "_sticky"}, {31'd0, sticky_ov}, 0);
    chk({tag, "_ov_count"}, {24'd0, ov_count}, 0);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] z;
    logic       ov;
    int         nov;

    rst = 1'b1;
    in_valid = 1'b0;
    in_z = '0;
    in_ov = 1'b0;
    in_op = '0;
    out_ready = 1'b0;
    clr_status = 1'b0;
    s_in_valid = 1'b0;
    s_in_z = '0;
    s_in_ov = 1'b0;
    s_in_op = '0;
    s_out_ready = 1'b1;
    s_clr_status = 1'b0;
    step();
    step();
    check_reset_vals("rst0");
    rst = 1'b0;
    step();

    // 100 - (-100) = 200 wraps to 0xC8 with overflow
    send(8'hC8, 1'b1, OP_SUB);
    chk("sub_out_valid", {31'd0, out_valid}, 1);
    chk("sub_out_z", {24'd0, out_z}, 32'hC8);
    chk("sub_out_ov", {31'd0, out_ov}, 1);
    chk("sub_out_op", {29'd0, out_op}, {29'd0, OP_SUB});
    chk("sub_sticky", {31'd0, sticky_ov}, 1);
    chk("sub_ov_count", {24'd0, ov_count}, 1);
    out_ready = 1'b1;
    drain();

    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, OP_ADD);
    chk("fill_full_ready", {31'd0, in_ready}, 0);
    in_z = 8'd5;
    in_ov = 1'b0;
    in_op = OP_ADD;
    in_valid = 1'b1;
    sb.push_back('{op: OP_ADD, ov: 1'b0, z: 8'd5});
    step();
    step();
    chk("fill_held_ready", {31'd0, in_ready}, 0);
    chk("fill_head_z", {24'd0, out_z}, 1);
    out_ready = 1'b1;
    step();
    chk("fill_after_pop_ready", {31'd0, in_ready}, 1);
    step();
    in_valid = 1'b0;
    drain();

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'(8'h10 + i), 1'b0, OP_XOR);
    chk("mid_valid", {31'd0, out_valid}, 1);
    rst = 1'b1;
    sb.delete();
    step();
    step();
    check_reset_vals("rst_mid");
    rst = 1'b0;
    step();
    chk("post_rst_valid", {31'd0, out_valid}, 0);

    nov = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      z = a - b;
      ov = (a[7] ^ b[7]) & (z[7] ^ a[7]);
      nov += int'(ov);
      in_z = z;
      in_ov = ov;
      in_op = OP_SUB;
      sb.push_back('{op: OP_SUB, ov: ov, z: z});
      step();
      chk("stream_in_ready", {31'd0, in_ready}, 1);
      chk("stream_out_valid", {31'd0, out_valid}, 1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_empty", {31'd0, out_valid}, 0);
    chk("stream_ov_count", {24'd0, ov_count}, 32'(nov));
    chk("stream_queue", 32'(sb.size()), 0);

    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    chk("clr_sticky", {31'd0, sticky_ov}, 0);
    chk("clr_ov_count", {24'd0, ov_count}, 0);
    for (int i = 0; i < 3; i++) send(8'(8'h80 + i), 1'b1, OP_SUB);
    chk("pre_coll_count", {24'd0, ov_count}, 3);
    in_z = 8'h7F;
    in_ov = 1'b1;
    in_op = OP_SUB;
    in_valid = 1'b1;
    clr_status = 1'b1;
    sb.push_back('{op: OP_SUB, ov: 1'b1, z: 8'h7F});
    step();
    in_valid = 1'b0;
    clr_status = 1'b0;
    chk("coll_ov_count", {24'd0, ov_count}, 1);
    chk("coll_sticky", {31'd0, sticky_ov}, 1);
    drain();

    s_in_ov = 1'b1;
    s_in_op = OP_SUB;
    s_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_in_z = 8'(8'hA0 + i);
      step();
      chk("sat_ov_count", {30'd0, s_ov_count}, (i < 3) ? 32'(i + 1) : 32'd3);
    end
    s_in_valid = 1'b0;
    step();
    chk("sat_final", {30'd0, s_ov_count}, 3);
    chk("sat_sticky", {31'd0, s_sticky_ov}, 1);

    chk("final_queue", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered result-collection stage directly downstream of the combinational ALU. It captures each ALU result word `Z`, overflow flag `OV` and the opcode that produced it into a small FIFO, then hands results to the consumer over a valid/ready handshake. It also maintains a sticky overflow status and a saturating overflow event counter for the control/status path.

## Interface

Parameters:
- `nIO`, 8, ALU data width; must match the ALU's `nIO`.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `CNT_W`, 8, overflow counter width.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: ALU result on `in_z`/`in_ov`/`in_op` is valid.
- `in_ready` out 1: stage can accept a result this cycle.
- `in_z` in `nIO`: ALU `Z`, signed two's complement.
- `in_ov` in 1: ALU `OV`.
- `in_op` in 3: ALU `OP` for this result.
- `out_valid` out 1: head entry available.
- `out_ready` in 1: consumer accepts head entry.
- `out_z` out `nIO`: head result.
- `out_ov` out 1: head overflow flag.
- `out_op` out 3: head opcode.
- `sticky_ov` out 1: set once any accepted result had `in_ov`=1.
- `ov_count` out `CNT_W`: number of accepted overflowed results, saturating.
- `clr_status` in 1: clears `sticky_ov` and `ov_count`.

Clock is `clk`. Reset is `rst`, which is synchronous and active-high. No other clocks.

## Operation

- Storage: circular FIFO of `DEPTH` entries {op[2:0], ov, z[nIO-1:0]}. It uses a write pointer, a read pointer, and an occupancy count of width clog2(DEPTH)+1.
- Push when `in_valid && in_ready`. `in_ready = (count != DEPTH)`. No pass-through when full: `in_ready` stays 0 for the whole cycle even if a pop occurs.
- Pop when `out_valid && out_ready`. `out_valid = (count != 0)`. `out_*` come from the entry at the read pointer.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers wrap modulo `DEPTH`.
- Data is stored unmodified. No sign extension and no recomputation of overflow.
- Status, applied on each push:
  - If `in_ov`=1, set `sticky_ov`.
  - If `in_ov`=1, increment `ov_count`. It saturates at all-ones and never wraps.
- `clr_status`=1 zeroes the status for that cycle. If an overflowed push happens in the same cycle, the push wins over the old value: `sticky_ov`=1 and `ov_count`=1.
- Status counts only accepted pushes. Results offered while `in_ready`=0 are not counted.
- Upstream must hold `in_*` stable while `in_valid`=1 and `in_ready`=0. The stage does not check this.

## Timing

- Reset values, all outputs: `in_ready`=1, `out_valid`=0, `out_z`=0, `out_ov`=0, `out_op`=0, `sticky_ov`=0, `ov_count`=0. Pointers and count are also 0.
- Reset mid-operation discards all stored entries. No partial pop completes.
- Latency: a push at edge N makes `out_valid`=1 after edge N, i.e. one cycle of latency when empty.
- Throughput: one result per cycle when `out_ready` is held high.
- `in_ready` and `out_valid` depend only on registered count. There is no combinational path from `out_ready` to `in_ready`.
- Status outputs update on the edge of the accepting push.

## Structure

- Shared package `alu_pkg`:
  - default `nIO`=8
  - opcode constants, including `OP_SUB = 3'b001`
  - a packed result-entry typedef {op, ov, z}
- Natural sub-module: `alu_result_fifo`, a generic `DEPTH`×width FIFO with pointers and count.
- The top level adds the status logic (`sticky_ov`, `ov_count`, `clr_status`) and the port mapping.

## Test plan

- **Reset:** assert `rst` for 2 cycles mid-stream with 3 entries held. Required: outputs are at their reset values; `out_valid`=0 on the next cycle.
- **Single subtract overflow:** ALU runs A=100, B=-100 with OP=001, so `in_z`=8'hC8 and `in_ov`=1; push once. Required: next cycle `out_valid`=1, `out_z`=8'hC8, `out_ov`=1, `out_op`=3'b001, `sticky_ov`=1, `ov_count`=1.
- **Fill and stall:** `out_ready`=0; push 5 results (z=1..5).
  - Required: `in_ready`=0 after the 4th push, and the 5th result is held.
  - Then raise `out_ready`. Required: outputs in order 1,2,3,4,5; the 5th is accepted the cycle after the first pop.
- **Streaming:** `in_valid` and `out_ready` both held at 1 for 20 cycles with random subtract results. Required: count stays at 1; order is preserved; `ov_count` equals the number of pushes with OV=1.
- **Clear collision:** with `ov_count`=3, assert `clr_status` in the same cycle as a push with `in_ov`=1. Required: `ov_count`=1, `sticky_ov`=1. Also `clr_status` alone yields 0/0.
- **Saturation:** `CNT_W`=2; push 5 overflowed results. Required: `ov_count` ends at 3 and does not wrap to 0.
